// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed on-chip RAM.
// One transaction at a time; INCR/FIXED bursts up to 16 beats, byte-strobed writes.
module axi_sram_slave #(
    parameter int unsigned MEM_AW = 12
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_e;

    state_e              state_q, state_d;
    logic                en_q, en_d;
    logic [3:0]          id_q, id_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    logic [3:0]          beat_q, beat_d;
    logic                err_q, err_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;

    logic [31:0]         mem [0:(1<<MEM_AW)-1];
    logic [31:0]         mem_rd_q;
    logic                rd_en;
    logic [MEM_AW-1:0]   rd_addr;
    logic                mem_we;
    logic [MEM_AW-1:0]   addr_nxt;

    logic unused_ok;
    assign unused_ok = ^{arsize, arlock, arcache, arprot, araddr[1:0], araddr[31:MEM_AW+2],
                         awsize, awlock, awcache, awprot, awaddr[1:0], awaddr[31:MEM_AW+2]};

    assign addr_nxt = (burst_q == 2'b00) ? addr_q : addr_q + MEM_AW'(1);

    assign awready = en_q && (state_q == IDLE);
    assign arready = en_q && (state_q == IDLE) && !awvalid;
    assign wready  = en_q && (state_q == WR);
    assign bvalid  = en_q && (state_q == WRESP);
    assign bid     = bvalid ? id_q : '0;
    assign bresp   = (bvalid && err_q) ? 2'b10 : 2'b00;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rvalid_q ? id_q : '0;
    assign rresp   = 2'b00;
    // RAM read register is only refreshed on AR or R handshakes, so rdata holds under stall.
    assign rdata   = rvalid_q ? mem_rd_q : '0;

    always_comb begin
        state_d  = state_q;
        en_d     = 1'b1;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        err_d    = err_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        rd_en    = 1'b0;
        rd_addr  = addr_nxt;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_q && awvalid) begin
                    id_d    = awid;
                    addr_d  = awaddr[MEM_AW+1:2];
                    len_d   = awlen;
                    burst_d = awburst;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = WR;
                end else if (en_q && arvalid) begin
                    id_d     = arid;
                    addr_d   = araddr[MEM_AW+1:2];
                    len_d    = arlen;
                    burst_d  = arburst;
                    beat_d   = '0;
                    rd_en    = 1'b1;
                    rd_addr  = araddr[MEM_AW+1:2];
                    rvalid_d = 1'b1;
                    rlast_d  = (arlen == 4'd0);
                    state_d  = RD;
                end
            end
            RD: begin
                if (rready) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        addr_d  = addr_nxt;
                        rd_en   = 1'b1;
                        rlast_d = ((beat_q + 4'd1) == len_q);
                    end
                end
            end
            WR: begin
                if (wvalid) begin
                    mem_we = 1'b1;
                    beat_d = beat_q + 4'd1;
                    addr_d = addr_nxt;
                    if ((wid != id_q) || (wlast != (beat_q == len_q)))
                        err_d = 1'b1;
                    if (beat_q == len_q)
                        state_d = WRESP;
                end
            end
            WRESP: begin
                if (bready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb[b])
                    mem[addr_q][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (rd_en)
            mem_rd_q <= mem[rd_addr];
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: reference RAM model feeds R/B scoreboards.
module tb_axi_sram_slave;

    logic        aclk, aresetn;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    axi_sram_slave #(.MEM_AW(12)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mdl [0:4095];
    logic [36:0] rq [$];
    logic [5:0]  bq [$];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [3:0]  wi [16];
    logic        wl [16];
    logic        pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prep_write(input logic [3:0] id, input logic [3:0] len, input logic [31:0] base);
        for (int b = 0; b < 16; b++) begin
            wd[b] = base + 32'(b);
            ws[b] = 4'hF;
            wi[b] = id;
            wl[b] = (b == int'(len));
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                            input logic [1:0] burst, input bit ar_collide);
        logic [11:0] a;
        logic        err;
        logic [5:0]  e;
        int          c;
        err = 1'b0;
        a = addr[13:2];
        for (int b = 0; b <= int'(len); b++) begin
            if (wi[b] != id || wl[b] != (b == int'(len))) err = 1'b1;
            for (int k = 0; k < 4; k++)
                if (ws[b][k]) mdl[a][8*k +: 8] = wd[b][8*k +: 8];
            if (burst != 2'b00) a = a + 12'd1;
        end
        bq.push_back({id, err ? 2'b10 : 2'b00});
        awaddr = addr; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
        c = 0;
        @(negedge aclk);
        if (ar_collide) begin
            chk("collide_arready", arready, 0);
            chk("collide_awready", awready, 1);
        end
        while (!awready && c < 50) begin @(negedge aclk); c++; end
        chk("aw_accept", awready, 1);
        @(posedge aclk); #1 awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wid = wi[b]; wlast = wl[b];
            c = 0;
            @(negedge aclk);
            while (!wready && c < 50) begin @(negedge aclk); c++; end
            chk("w_accept", wready, 1);
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        @(negedge aclk);
        chk("b_latency", bvalid, 1);
        c = 0;
        while (!bvalid && c < 50) begin @(negedge aclk); c++; end
        e = bq.pop_front();
        chk("bid", bid, e[5:2]);
        chk("bresp", bresp, e[1:0]);
        @(posedge aclk); #1 bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                           input logic [1:0] burst, input bit use_pat);
        logic [11:0] a;
        logic [36:0] e;
        int          c;
        a = addr[13:2];
        for (int b = 0; b <= int'(len); b++) begin
            rq.push_back({(b == int'(len)), id, mdl[a]});
            if (burst != 2'b00) a = a + 12'd1;
        end
        araddr = addr; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
        c = 0;
        @(negedge aclk);
        while (!arready && c < 50) begin @(negedge aclk); c++; end
        chk("ar_accept", arready, 1);
        @(posedge aclk); #1 arvalid = 1'b0;
        c = 0;
        rready = use_pat ? pat[0] : 1'b1;
        @(negedge aclk);
        chk("r_first_valid", rvalid, 1);
        while (rq.size() > 0 && c < 100) begin
            if (rvalid && rready) begin
                e = rq.pop_front();
                chk("rdata", rdata, e[31:0]);
                chk("rid", rid, e[35:32]);
                chk("rlast", rlast, e[36]);
                chk("rresp", rresp, 0);
            end else if (rvalid) begin
                chk("r_hold", rdata, rq[0][31:0]);
            end
            @(posedge aclk); #1;
            c++;
            rready = (use_pat && c < 7) ? pat[c] : 1'b1;
            @(negedge aclk);
        end
        if (rq.size() > 0) begin
            chk("r_timeout", rq.size(), 0);
            rq.delete();
        end else begin
            chk("r_end_rvalid", rvalid, 0);
            chk("r_end_arready", arready, 1);
        end
        rready = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_rid"}, rid, 0);
        chk({tag, "_rlast"}, rlast, 0);
        chk({tag, "_rresp"}, rresp, 0);
        chk({tag, "_arready"}, arready, 0);
        chk({tag, "_awready"}, awready, 0);
        chk({tag, "_wready"}, wready, 0);
        chk({tag, "_bvalid"}, bvalid, 0);
        chk({tag, "_bid"}, bid, 0);
        chk({tag, "_bresp"}, bresp, 0);
    endtask

    initial begin
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

        #23;
        chk_reset_outputs("por");
        @(posedge aclk); #2 aresetn = 1'b1;
        @(negedge aclk); chk("por_en_arready0", arready, 0);
        @(negedge aclk); chk("por_en_arready1", arready, 1);
        @(posedge aclk); #1;

        // Preload via the write channel.
        prep_write(4'd0, 4'd0, 32'h12345678);
        do_write(32'h100, 4'd0, 4'd0, 2'b01, 1'b0);
        prep_write(4'd1, 4'd3, 32'h0);
        do_write(32'h0, 4'd1, 4'd3, 2'b01, 1'b0);
        prep_write(4'd0, 4'd0, 32'hAABBCCDD);
        do_write(32'h14, 4'd0, 4'd0, 2'b01, 1'b0);

        do_read(32'h100, 4'd3, 4'd0, 2'b01, 1'b0);
        do_read(32'h0, 4'd4, 4'd3, 2'b01, 1'b1);
        do_read(32'h0, 4'd5, 4'd3, 2'b00, 1'b1);

        // Byte strobes 0101 onto 0xAABBCCDD.
        prep_write(4'd6, 4'd0, 32'h11223344);
        ws[0] = 4'b0101;
        do_write(32'h14, 4'd6, 4'd0, 2'b01, 1'b0);
        do_read(32'h14, 4'd6, 4'd0, 2'b01, 1'b0);
        chk("strobe_merge_model", mdl[5], 32'hAA22CC44);

        // AR and AW together: write wins, read follows and sees the new data.
        prep_write(4'd7, 4'd0, 32'hCAFEF00D);
        araddr = 32'h20; arid = 4'd8; arlen = 4'd0; arburst = 2'b01; arvalid = 1'b1;
        do_write(32'h20, 4'd7, 4'd0, 2'b01, 1'b1);
        do_read(32'h20, 4'd8, 4'd0, 2'b01, 1'b0);

        // Wrong wid on beat 0; both beats still land.
        prep_write(4'd2, 4'd1, 32'h5A5A0000);
        wi[0] = 4'd5;
        do_write(32'h200, 4'd2, 4'd1, 2'b01, 1'b0);
        do_read(32'h200, 4'd2, 4'd1, 2'b01, 1'b0);

        // Early wlast on beat 0 of a 2-beat burst.
        prep_write(4'd3, 4'd1, 32'h77770000);
        wl[0] = 1'b1;
        do_write(32'h300, 4'd3, 4'd1, 2'b01, 1'b0);

        // Missing wlast on the final beat still ends the burst.
        prep_write(4'd4, 4'd1, 32'h66660000);
        wl[1] = 1'b0;
        do_write(32'h340, 4'd4, 4'd1, 2'b01, 1'b0);

        // Address wraps at the top of the RAM; high address bits alias.
        prep_write(4'd9, 4'd1, 32'hF00D0000);
        do_write(32'h3FFC, 4'd9, 4'd1, 2'b01, 1'b0);
        do_read(32'hFFFC, 4'd9, 4'd1, 2'b01, 1'b0);
        do_read(32'h4100, 4'd1, 4'd0, 2'b01, 1'b0);

        // Reset during beat 1 of a 4-beat read.
        araddr = 32'h0; arid = 4'd10; arlen = 4'd3; arburst = 2'b01; arvalid = 1'b1;
        @(negedge aclk);
        chk("rst_ar_accept", arready, 1);
        @(posedge aclk); #1 arvalid = 1'b0; rready = 1'b1;
        @(negedge aclk);
        chk("rst_beat0_valid", rvalid, 1);
        @(posedge aclk); #3 aresetn = 1'b0;
        #1 chk_reset_outputs("midrst");
        rready = 1'b0;
        @(posedge aclk); #2 aresetn = 1'b1;
        @(negedge aclk); chk("midrst_arready0", arready, 0);
        @(negedge aclk); chk("midrst_arready1", arready, 1);
        @(posedge aclk); #1;

        do_read(32'h100, 4'd11, 4'd0, 2'b01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
